// File: rtl/audio_sample_rx_pwm.sv
// DAC-side receiver of the 4-phase req/ack audio sample link. A sample is captured
// into a pending register and reaches the PWM duty only at a period boundary.
module audio_sample_rx_pwm #(
    parameter int DATA_WIDTH   = 12,
    parameter int SYNC_STAGES  = 2,
    parameter int RESET_SAMPLE = 2048
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tx_req,
    input  logic [DATA_WIDTH-1:0] to_cdc,
    output logic                  tx_ack,
    output logic                  pwm_out,
    output logic [DATA_WIDTH-1:0] duty,
    output logic                  sample_loaded,
    output logic                  overrun
);

    localparam logic [DATA_WIDTH-1:0] RST_VAL = DATA_WIDTH'(RESET_SAMPLE);
    localparam logic [DATA_WIDTH-1:0] CNT_MAX = {DATA_WIDTH{1'b1}};
    localparam logic [DATA_WIDTH-1:0] CNT_ONE = DATA_WIDTH'(1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  sync_q, sync_d;
    logic                    tx_ack_q, tx_ack_d;
    logic [DATA_WIDTH-1:0]   pending_q, pending_d;
    logic                    pending_valid_q, pending_valid_d;
    logic [DATA_WIDTH-1:0]   duty_q, duty_d;
    logic [DATA_WIDTH-1:0]   pwm_cnt_q, pwm_cnt_d;
    logic                    pwm_out_q, pwm_out_d;
    logic                    sample_loaded_q, sample_loaded_d;
    logic                    overrun_q, overrun_d;
    logic                    req_s;
    logic                    capture_s;
    logic                    load_s;

    assign req_s = sync_q[SYNC_STAGES-1];

    // Handshake FSM: capture to_cdc once per request, ack follows the synchronised request
    always_comb begin
        state_d   = state_q;
        tx_ack_d  = tx_ack_q;
        capture_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_s) begin
                    capture_s = 1'b1;
                    tx_ack_d  = 1'b1;
                    state_d   = ST_ACK;
                end else begin
                    tx_ack_d  = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            ST_ACK: begin
                if (!req_s) begin
                    tx_ack_d = 1'b0;
                    state_d  = ST_IDLE;
                end else begin
                    tx_ack_d = 1'b1;
                    state_d  = ST_ACK;
                end
            end
            default: begin
                tx_ack_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    // Pending/duty bookkeeping; a same-cycle load takes the old pending before capture overwrites it
    always_comb begin
        sync_d          = {sync_q[SYNC_STAGES-2:0], tx_req};
        pending_d       = pending_q;
        pending_valid_d = pending_valid_q;
        duty_d          = duty_q;
        overrun_d       = overrun_q;
        load_s          = (pwm_cnt_q == CNT_MAX) && pending_valid_q;
        if (load_s) begin
            duty_d          = pending_q;
            pending_valid_d = 1'b0;
        end else begin
            duty_d          = duty_q;
        end
        if (capture_s) begin
            pending_d       = to_cdc;
            pending_valid_d = 1'b1;
            if (pending_valid_q && !load_s) begin
                overrun_d = 1'b1;
            end else begin
                overrun_d = overrun_q;
            end
        end else begin
            pending_d = pending_q;
        end
        sample_loaded_d = load_s;
        pwm_cnt_d       = pwm_cnt_q + CNT_ONE;
        pwm_out_d       = (pwm_cnt_q < duty_q);
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            sync_q          <= {SYNC_STAGES{1'b0}};
            tx_ack_q        <= 1'b0;
            pending_q       <= RST_VAL;
            pending_valid_q <= 1'b0;
            duty_q          <= RST_VAL;
            pwm_cnt_q       <= {DATA_WIDTH{1'b0}};
            pwm_out_q       <= 1'b0;
            sample_loaded_q <= 1'b0;
            overrun_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            sync_q          <= sync_d;
            tx_ack_q        <= tx_ack_d;
            pending_q       <= pending_d;
            pending_valid_q <= pending_valid_d;
            duty_q          <= duty_d;
            pwm_cnt_q       <= pwm_cnt_d;
            pwm_out_q       <= pwm_out_d;
            sample_loaded_q <= sample_loaded_d;
            overrun_q       <= overrun_d;
        end
    end

    assign tx_ack        = tx_ack_q;
    assign pwm_out       = pwm_out_q;
    assign duty          = duty_q;
    assign sample_loaded = sample_loaded_q;
    assign overrun       = overrun_q;

endmodule
